// File: rtl/uart_tx_frame.sv
// UART transmit engine: one byte per valid/ready handshake, sent LSB-first as
// start / 8 data / optional parity / 1-2 stop bits on a registered txd.
module uart_tx_frame #(
   parameter int unsigned BPS_T     = 433,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       txd
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   localparam logic [15:0] BPS_LIM = 16'(BPS_T);

   state_e      state_q,  state_d;
   logic [15:0] cnt_q,    cnt_d;
   logic [2:0]  idx_q,    idx_d;
   logic [7:0]  shift_q,  shift_d;
   logic        par_q,    par_d;
   logic        stop2_q,  stop2_d;
   logic        txd_q,    txd_d;
   logic        ready_q,  ready_d;
   logic        done_q,   done_d;

   logic bit_end;
   assign bit_end = (cnt_q == BPS_LIM);

   always_comb begin
      // NOTE: every next-state signal is defaulted first so no path through the
      // case statement leaves one unassigned, which would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      stop2_d = stop2_q;
      txd_d   = txd_q;
      ready_d = ready_q;
      done_d  = 1'b0;

      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            cnt_d = 16'd0;
            if (tx_valid) begin
               shift_d = tx_data;
               par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
               state_d = S_START;
               txd_d   = 1'b0;
               ready_d = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = 3'd0;
               txd_d   = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                     txd_d   = par_q;
                  end else begin
                     state_d = S_STOP;
                     txd_d   = 1'b1;
                     stop2_d = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
                  txd_d = shift_q[idx_q + 3'd1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               txd_d   = 1'b1;
               stop2_d = 1'b0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               // A second stop period reuses the same counter; txd simply stays high.
               if (STOP_BITS == 2 && !stop2_q) begin
                  stop2_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  idx_d   = 3'd0;
                  ready_d = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         idx_q   <= 3'd0;
         shift_q <= 8'd0;
         par_q   <= 1'b0;
         stop2_q <= 1'b0;
         txd_q   <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // values sampled at this edge, independent of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         stop2_q <= stop2_d;
         txd_q   <= txd_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   assign txd      = txd_q;
   assign tx_ready = ready_q;
   assign tx_done  = done_q;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit engine; the transmit-side counterpart of the receive path's mid-bit sampling baud counter. Accepts one byte per valid/ready handshake, serialises it LSB-first as start / 8 data / optional parity / 1-2 stop bits on txd. Owns its own per-bit baud counter, so it shares no timing with the receiver and needs only clk. Sits between the byte-producing logic (command/response FSM) and the board TX pin.

Parameters:
BPS_T, 433, clocks per bit minus 1 (bit period = BPS_T+1 clk; 433 gives 115200 baud at 50 MHz); legal range 1..65535.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous, active-low.
tx_valid  in  1  byte offered on tx_data.
tx_data  in  8  byte to send; sampled only on the accept edge.
tx_ready  out  1  high when idle and able to accept.
tx_done  out  1  one-cycle pulse at end of frame.
txd  out  1  serial line, idle high, registered.

Behaviour:
- Reset (async, any time including mid-frame): state IDLE, txd=1, tx_ready=1, tx_done=0, baud counter=0, bit index=0, shift register=0. The line returns high immediately. No partial frame resumes after reset.
- Accept: rising edge with tx_valid=1 and tx_ready=1. On that edge:
  - tx_data is latched.
  - If PARITY≠0, the parity bit is computed from the latched byte: odd gives ~^data, even gives ^data.
  - state→START, txd←0, tx_ready←0, counter←0.
- tx_valid while tx_ready=0 is ignored. There is no queue. tx_data changes after accept have no effect.
- Baud counter: 16-bit. Increments every clk while not IDLE. When count==BPS_T, it clears to 0 and the FSM advances one bit. Every bit, including each stop bit, is held for exactly BPS_T+1 clocks.
- FSM:
  - IDLE: txd=1; go to START on accept.
  - START: txd=0; then DATA with bit index 0.
  - DATA: txd=data[idx], idx increments 0..7; after bit 7 go to PARITY if PARITY≠0, else STOP.
  - PARITY: txd=parity bit; then STOP.
  - STOP: txd=1 for STOP_BITS bit periods; then IDLE.
- All txd transitions occur on the edge where the state/bit changes, so txd is glitch-free (register output).
- End of frame: on the edge leaving STOP, the block sets tx_ready←1 and tx_done←1 (one cycle; cleared next edge), and txd stays 1.
- Frame latency: accept edge to tx_done-high edge is exactly N×(BPS_T+1) clocks, where N = 1+8+(PARITY≠0)+STOP_BITS.
- Back-to-back: with tx_valid held high, the next accept occurs in the tx_done cycle. The minimum inter-frame gap is therefore the stop bit(s) plus 1 idle clk.
- tx_done and accept may coincide in one cycle; both take effect.
- Illegal parameters (PARITY=3, STOP_BITS∉{1,2}) are behaviour-undefined. The simulation bench flags them at elaboration.

Test Plan:
1. BPS_T=3, PARITY=0, STOP_BITS=1; send 0x55 -> txd, 4 clk per level: 0,1,0,1,0,1,0,1,0,1. tx_done pulses exactly 40 clk after the accept edge. tx_ready is low for those 40 clk.
2. BPS_T=3, PARITY=2 (even), send 0x07 -> parity bit 1. PARITY=1 (odd), send 0x07 -> parity bit 0. Frame is 44 clk (11 bits). With STOP_BITS=2, even parity, 0x07: frame is 48 clk with txd=1 for the final 8 clk.
3. BPS_T=3, tx_valid held high with 0xA5 then 0x3C -> second start bit begins 1 clk after the first tx_done edge. The line decodes as 0xA5 then 0x3C. The byte presented while busy (0xFF) is never sent.
4. Default BPS_T=433, send 0x00 -> txd low for 9×434=3906 clk, then high. tx_done fires at 4340 clk.
5. Change tx_data mid-frame and pulse tx_valid during DATA -> the transmitted byte is unchanged, with no second accept.
6. Assert rst_n=0 in the middle of data bit 3 -> txd=1 and tx_ready=1 asynchronously, with no tx_done. A fresh send after release produces a complete, correct frame.
